// File: rtl/nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nco_sweep_ctrl
//
// Sequencer for a phase-accumulator / pulse-counting datapath. It steps the
// accumulator increment through a programmed linear sweep. At each step it
// clears the accumulator phase, lets the accumulator settle, and counts its
// carry pulses over a fixed gate window. Each count is then offered on a
// valid/ready result port.
//
// Optional feature macro: NCO_SWEEP_PEAK_EN
//   defined   : tracks the largest result_count of the sweep and its step index
//   undefined : peak_count / peak_index are tied to zero and no logic is built
//
// Parameters
//   ACC_W          accumulator / increment width
//   CNT_W          pulse-count width (count saturates at all-ones)
//   GATE_CYCLES    gate window length in clk cycles (>= 1)
//   SETTLE_CYCLES  cycles after each increment change where carries are ignored
//   IDX_W          step index / step count width
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           begin a sweep (sampled in IDLE only)
//   abort           abandon the sweep (sampled in every non-IDLE state)
//   start_inc       first increment       (captured on accepted start)
//   step_inc        per-step delta        (captured on accepted start)
//   num_steps       measurement steps     (captured on accepted start)
//   acc_value       increment driven to the accumulator
//   acc_clear       one-cycle accumulator phase clear
//   carry           accumulator carry pulse input
//   busy            high in every state except IDLE
//   result_valid    result available
//   result_ready    consumer accepts result
//   result_index    0-based step number of the current result
//   result_count    carries counted in that step's gate window
//   done            one-cycle pulse at normal sweep completion
//   peak_count      largest result_count seen this sweep
//   peak_index      step index of peak_count (lowest index on ties)
// -----------------------------------------------------------------------------
module nco_sweep_ctrl #(
   parameter int ACC_W         = 32,
   parameter int CNT_W         = 32,
   parameter int GATE_CYCLES   = 100000,
   parameter int SETTLE_CYCLES = 4,
   parameter int IDX_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [ACC_W-1:0] start_inc,
   input  logic [ACC_W-1:0] step_inc,
   input  logic [IDX_W-1:0] num_steps,
   output logic [ACC_W-1:0] acc_value,
   output logic             acc_clear,
   input  logic             carry,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [IDX_W-1:0] result_index,
   output logic [CNT_W-1:0] result_count,
   output logic             done,
   output logic [CNT_W-1:0] peak_count,
   output logic [IDX_W-1:0] peak_index
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_GATE,
      S_REPORT,
      S_DONE
   } state_e;

   // One down-counter times both the settle and the gate window; it only has
   // to hold the larger of the two reload values (length - 1).
   localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYCLES - 1);
   localparam logic [TMR_W-1:0] SETTLE_LD =
      TMR_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e             state_q,     state_d;
   logic [ACC_W-1:0]   acc_q,       acc_d;
   logic [ACC_W-1:0]   step_q,      step_d;
   logic [IDX_W-1:0]   nsteps_q,    nsteps_d;
   logic [IDX_W-1:0]   index_q,     index_d;
   logic [CNT_W-1:0]   count_q,     count_d;
   logic [TMR_W-1:0]   timer_q,     timer_d;

   logic               last_step;

   assign last_step = (index_q == (nsteps_q - IDX_W'(1)));

   // --------------------------------------------------------------------------
   // Next-state and output decode
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // through the case statement can leave it unassigned and infer a latch.
      state_d      = state_q;
      acc_d        = acc_q;
      step_d       = step_q;
      nsteps_d     = nsteps_q;
      index_d      = index_q;
      count_d      = count_q;
      timer_d      = timer_q;
      acc_clear    = 1'b0;
      result_valid = 1'b0;
      done         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               step_d   = step_inc;
               nsteps_d = num_steps;
               index_d  = '0;
               if (num_steps == '0) begin
                  state_d = S_DONE;
               end else begin
                  acc_d   = start_inc;
                  state_d = S_LOAD;
               end
            end
         end

         S_LOAD: begin
            acc_clear = 1'b1;
            count_d   = '0;
            if (SETTLE_CYCLES == 0) begin
               timer_d = GATE_LD;
               state_d = S_GATE;
            end else begin
               timer_d = SETTLE_LD;
               state_d = S_SETTLE;
            end
         end

         S_SETTLE: begin
            if (timer_q == '0) begin
               timer_d = GATE_LD;
               state_d = S_GATE;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end

         S_GATE: begin
            // Saturating count: once all-ones, further carries are dropped.
            if (carry && (count_q != CNT_MAX)) begin
               count_d = count_q + CNT_W'(1);
            end
            if (timer_q == '0) begin
               state_d = S_REPORT;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end

         S_REPORT: begin
            result_valid = 1'b1;
            if (result_ready) begin
               if (last_step) begin
                  state_d = S_DONE;
               end else begin
                  // Increment wraps modulo 2^ACC_W by design.
                  acc_d   = acc_q + step_q;
                  index_d = index_q + IDX_W'(1);
                  state_d = S_LOAD;
               end
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over everything else: it suppresses the result handshake
      // and the done pulse in the same cycle and leaves acc_value untouched.
      if ((state_q != S_IDLE) && abort) begin
         state_d      = S_IDLE;
         acc_d        = acc_q;
         index_d      = index_q;
         result_valid = 1'b0;
         done         = 1'b0;
      end
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         step_q   <= '0;
         nsteps_q <= '0;
         index_q  <= '0;
         count_q  <= '0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         step_q   <= step_d;
         nsteps_q <= nsteps_d;
         index_q  <= index_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
      end
   end

   assign acc_value    = acc_q;
   assign busy         = (state_q != S_IDLE);
   assign result_index = index_q;
   assign result_count = count_q;

   // --------------------------------------------------------------------------
   // Optional peak tracking
   // --------------------------------------------------------------------------
`ifdef NCO_SWEEP_PEAK_EN
   logic [CNT_W-1:0] peak_count_q, peak_count_d;
   logic [IDX_W-1:0] peak_index_q, peak_index_d;
   logic             peak_clr;
   logic             peak_upd;

   assign peak_clr = (state_q == S_IDLE) && start;
   // result_valid is already masked by abort, so an aborted handshake never
   // updates the peak.
   assign peak_upd = result_valid && result_ready;

   always_comb begin
      peak_count_d = peak_count_q;
      peak_index_d = peak_index_q;
      if (peak_clr) begin
         peak_count_d = '0;
         peak_index_d = '0;
      end else if (peak_upd && (count_q > peak_count_q)) begin
         // Strict compare keeps the lowest index on ties.
         peak_count_d = count_q;
         peak_index_d = index_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         peak_count_q <= '0;
         peak_index_q <= '0;
      end else begin
         peak_count_q <= peak_count_d;
         peak_index_q <= peak_index_d;
      end
   end

   assign peak_count = peak_count_q;
   assign peak_index = peak_index_q;
`else
   assign peak_count = '0;
   assign peak_index = '0;
`endif

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Sequencer for the phase-accumulator/pulse-counting datapath. It steps the accumulator increment through a programmed linear sweep and clears the accumulator phase at each step. It counts accumulator carry pulses over a fixed gate window per step and hands each count out through a valid/ready result port. It sits between a host (or test FSM) and one accumulator instance, driving that instance's increment input.

## Interface
- ACC_W, 32: accumulator/increment width
- CNT_W, 32: pulse-count width
- GATE_CYCLES, 100000: gate window length in clk cycles (≥1)
- SETTLE_CYCLES, 4: cycles after each increment change where carries are ignored (≥0)
- IDX_W, 16: step index / step count width

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sweep; sampled in IDLE only
- abort  in  1  abandon sweep; sampled in every non-IDLE state
- start_inc  in  ACC_W  first increment; captured on accepted start
- step_inc  in  ACC_W  per-step increment delta; captured on accepted start
- num_steps  in  IDX_W  number of measurement steps; captured on accepted start
- acc_value  out  ACC_W  increment driven to the accumulator
- acc_clear  out  1  one-cycle accumulator phase clear
- carry  in  1  accumulator carry, one clk-wide pulses
- busy  out  1  high in every state except IDLE
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- result_index  out  IDX_W  step number of current result (0-based)
- result_count  out  CNT_W  carries counted in that step's gate window
- done  out  1  one-cycle pulse at normal sweep completion
- peak_count, peak_index  out  CNT_W, IDX_W  see Configuration

## Operation
- States: IDLE, LOAD, SETTLE, GATE, REPORT, DONE.
- IDLE: start=1 captures start_inc/step_inc/num_steps. num_steps=0 -> DONE, otherwise -> LOAD with acc_value<=start_inc and index<=0. start in any other state is ignored.
- LOAD (1 cycle): acc_clear=1, pulse counter cleared -> SETTLE, or -> GATE if SETTLE_CYCLES=0.
- SETTLE: exactly SETTLE_CYCLES cycles; carry ignored -> GATE.
- GATE: exactly GATE_CYCLES cycles; each cycle with carry=1 increments count. Count saturates at 2^CNT_W-1 and does not wrap. -> REPORT.
- REPORT: result_valid=1; result_index and result_count stay stable until result_valid&&result_ready. On transfer: if index=num_steps-1 -> DONE; else acc_value<=acc_value+step_inc (mod 2^ACC_W, wraps silently), index++ -> LOAD.
- DONE (1 cycle): done=1 -> IDLE. acc_value keeps the last value used.
- abort=1 in any non-IDLE state -> IDLE on the next edge. No result transfer and no done pulse occur in that cycle. abort has priority over result_ready. acc_value is held.
- Reset values: state IDLE; acc_value 0, acc_clear 0, busy 0, result_valid 0, result_index 0, result_count 0, done 0, peak_count 0, peak_index 0. Reset mid-sweep discards all progress.

## Timing
- start high in cycle 0 (IDLE): LOAD in cycle 1, SETTLE in cycles 2..S+1, GATE in cycles S+2..S+G+1, result_valid first high in cycle S+G+2 (S=SETTLE_CYCLES, G=GATE_CYCLES).
- acc_value changes on the edge entering LOAD and is stable through SETTLE, GATE and REPORT.
- The result transfer edge enters the next LOAD directly. Step period is S+G+2 cycles plus any ready stall.
- done is high in the cycle after the final transfer. busy drops in the following cycle.
- carry is sampled registered only during GATE. A carry in the last GATE cycle is counted.

## Configuration
- NCO_SWEEP_PEAK_EN defined: the block tracks the maximum result_count and its index during the sweep. Ties keep the lowest index. Tracking clears on accepted start. peak_count and peak_index update on each result transfer and hold after done.
- Not defined: peak_count and peak_index are tied to 0 and no tracking logic is built.

## Test plan
- Bench uses GATE_CYCLES=100, SETTLE_CYCLES=4, and a real accumulator instance driven by acc_value/acc_clear.
- start_inc=2^31, step_inc=2^30, num_steps=2, result_ready=1 -> results (0,50), (1,75); first result_valid at cycle 106; done pulse after the second transfer.
- num_steps=0 -> done one cycle after start, no result_valid, busy high for exactly 1 cycle.
- result_ready held 0 for 20 cycles in REPORT -> result_valid, result_index and result_count stable throughout; acc_value unchanged until the transfer.
- carry forced to 1 every cycle with CNT_W=4 -> result_count saturates at 15.
- abort during GATE of step 1 of 3 -> IDLE next cycle, no done pulse. Then rst mid-sweep -> all outputs return to their reset values.
- With NCO_SWEEP_PEAK_EN: start_inc=2^30, step_inc=2^30, num_steps=3 (counts 25, 50, 75) -> peak_count=75, peak_index=2.
